// File: rtl/nn_pkg.sv
// Shared helpers for the neural-network datapath blocks:
// counter width sizing and a signedness-aware compare.
package nn_pkg;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic a_ge_b(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        sgn
  );
    if (sgn) return $signed(a) >= $signed(b);
    return a >= b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer holding the horizontal maxima of the even row.
// Synchronous write, asynchronous read; maps onto distributed RAM.
module pool_line_buf #(
  parameter int N     = 16,
  parameter int DEPTH = 12,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2d_unit.sv
// Streaming 2x2 / stride-2 max-pool over a raster pixel stream.
// One instance per feature-map channel.
module maxpool2d_unit
  import nn_pkg::*;
#(
  parameter int N      = 16,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  parameter int SIGNED = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         clr,
  input  logic         din_vld,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic         dout_vld,
  output logic         frame_done
);

  localparam int CW    = cnt_w(IMG_W);
  localparam int RW    = cnt_w(IMG_H);
  localparam int DEPTH = IMG_W / 2;
  localparam int AW    = cnt_w(DEPTH);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_END = CW'(2 * (IMG_W / 2) - 1);
  localparam logic [RW-1:0] ROW_END = RW'(2 * (IMG_H / 2) - 1);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [N-1:0]  h_reg;
  logic [N-1:0]  hmax;
  logic [N-1:0]  vmax;
  logic [N-1:0]  lb_rdata;
  logic [AW-1:0] lb_addr;
  logic          acc;
  logic          lb_we;

  function automatic logic [63:0] ext(input logic [N-1:0] v);
    if (SIGNED != 0) return 64'($signed(v));
    return 64'(v);
  endfunction

  assign acc     = rst_n && !clr && ce && din_vld;
  assign lb_addr = AW'(col_cnt >> 1);
  assign lb_we   = acc && col_cnt[0] && !row_cnt[0];

  always_comb begin
    hmax = din;
    vmax = lb_rdata;
    if (a_ge_b(ext(h_reg), ext(din), SIGNED != 0))
      hmax = h_reg;
    if (a_ge_b(ext(hmax), ext(lb_rdata), SIGNED != 0))
      vmax = hmax;
  end

  pool_line_buf #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_lb (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (hmax),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      h_reg      <= '0;
      dout       <= '0;
      dout_vld   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_vld   <= 1'b0;
      frame_done <= 1'b0;
      if (acc) begin
        if (col_cnt == COL_MAX) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == ROW_MAX) ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
        if (!col_cnt[0]) begin
          h_reg <= din;
        end else if (row_cnt[0]) begin
          dout       <= vmax;
          dout_vld   <= 1'b1;
          frame_done <= (row_cnt == ROW_END) && (col_cnt == COL_END);
        end
      end
    end
  end

endmodule
